// File: rtl/wishbone_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
// State encodings are plain localparams so legacy code can compare them directly.
package wishbone_arb_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ARB_IDLE    = 2'd0;
   localparam arb_state_t ARB_CONNECT = 2'd1;
   localparam arb_state_t ARB_STALL   = 2'd2;

   localparam int unsigned DEF_N_MASTERS      = 2;
   localparam int unsigned DEF_DW             = 128;
   localparam int unsigned DEF_AW             = 32;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

   // Index width that stays at least 1 bit when there is a single master.
   function automatic int unsigned gw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request after index 'last', wrapping mod N.
module rr_priority_picker
   import wishbone_arb_pkg::*;
#(
   parameter int unsigned N  = 2,
   parameter int unsigned GW = gw(N)
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] last,
   output logic [N-1:0]  win,
   output logic [GW-1:0] index,
   output logic          valid
);

   logic [N-1:0] rot;
   logic [N-1:0] rot_unused;

   // Rotating the doubled vector puts request last+1 at bit 0.
   assign {rot_unused, rot} = {req, req} >> (32'(last) + 32'd1);

   always_comb begin
      index = '0;
      valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            valid = 1'b1;
            index = GW'((32'(last) + 32'(k) + 32'd1) % N);
         end
      end
      win = valid ? (N'(1) << index) : '0;
   end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// N-master to 1-slave Wishbone arbiter, round-robin, registered grant, one stall cycle per ACK/RTY.
// Define WB_ARB_TIMEOUT_EN to abort transfers left unacknowledged for TIMEOUT_CYCLES cycles.
module wishbone_rr_arbiter
   import wishbone_arb_pkg::*;
#(
   parameter int unsigned N_MASTERS      = DEF_N_MASTERS,
   parameter int unsigned DW             = DEF_DW,
   parameter int unsigned AW             = DEF_AW,
   parameter int unsigned SW             = DW / 8,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_MASTERS-1:0]    m_cyc,
   input  logic [N_MASTERS-1:0]    m_stb,
   input  logic [N_MASTERS-1:0]    m_we,
   input  logic [N_MASTERS*SW-1:0] m_sel,
   input  logic [N_MASTERS*AW-1:0] m_adr,
   input  logic [N_MASTERS*DW-1:0] m_dat_m,
   output logic [N_MASTERS-1:0]    m_ack,
   output logic [N_MASTERS-1:0]    m_rty,
   output logic [N_MASTERS*DW-1:0] m_dat_s,
   output logic                    s_cyc,
   output logic                    s_stb,
   output logic                    s_we,
   output logic [SW-1:0]           s_sel,
   output logic [AW-1:0]           s_adr,
   output logic [DW-1:0]           s_dat_m,
   input  logic                    s_ack,
   input  logic                    s_rty,
   input  logic [DW-1:0]           s_dat_s,
   output logic [N_MASTERS-1:0]    grant,
   output logic                    timeout
);

   localparam int unsigned GW = gw(N_MASTERS);

   arb_state_t           state_q, state_d;
   logic [N_MASTERS-1:0] grant_q, grant_d;
   logic [GW-1:0]        gidx_q, gidx_d;
   logic [GW-1:0]        last_q, last_d;

   logic [N_MASTERS-1:0] req;
   logic [N_MASTERS-1:0] pick_win;
   logic [GW-1:0]        pick_idx;
   logic                 pick_valid;
   logic                 connect;
   logic                 done;
   logic                 to_hit;

   assign req     = m_cyc & m_stb;
   assign connect = (state_q == ARB_CONNECT);
   assign done    = s_ack | s_rty;
   assign grant   = grant_q;

   rr_priority_picker #(
      .N  (N_MASTERS),
      .GW (GW)
   ) u_picker (
      .req   (req),
      .last  (last_q),
      .win   (pick_win),
      .index (pick_idx),
      .valid (pick_valid)
   );

`ifdef WB_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Counter sits at zero outside CONNECT, so it is clear on every entry.
   assign cnt_d  = (connect && !done) ? cnt_q + 1'b1 : '0;
   assign to_hit = connect && !done && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign to_hit             = 1'b0;
`endif

   assign timeout = to_hit;

   always_comb begin
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      s_we    = 1'b0;
      s_sel   = '0;
      s_adr   = '0;
      s_dat_m = '0;
      m_ack   = '0;
      m_rty   = '0;
      m_dat_s = '0;
      if (connect) begin
         s_cyc                    = m_cyc[gidx_q] & ~to_hit;
         s_stb                    = m_stb[gidx_q] & ~to_hit;
         s_we                     = m_we[gidx_q];
         s_sel                    = m_sel[gidx_q*SW +: SW];
         s_adr                    = m_adr[gidx_q*AW +: AW];
         s_dat_m                  = m_dat_m[gidx_q*DW +: DW];
         m_ack[gidx_q]            = s_ack & ~to_hit;
         m_rty[gidx_q]            = s_rty | to_hit;
         m_dat_s[gidx_q*DW +: DW] = s_dat_s;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      case (state_q)
         ARB_IDLE, ARB_STALL: begin
            if (pick_valid) begin
               state_d = ARB_CONNECT;
               grant_d = pick_win;
               gidx_d  = pick_idx;
            end else begin
               state_d = ARB_IDLE;
               grant_d = '0;
            end
         end
         ARB_CONNECT: begin
            // Completion wins over a same-cycle CYC drop.
            if (done || to_hit) begin
               state_d = ARB_STALL;
               grant_d = '0;
               last_d  = gidx_q;
            end else if (!m_cyc[gidx_q]) begin
               state_d = ARB_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         last_q  <= GW'(N_MASTERS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
      end
   end

endmodule
